ct_lsu_wb_cmplt_arb: RTL

//  Parametrised completion write-back arbiter for one LSU->RTU WB pipe. Merges NUM_REQ completion

---
 rtl/ct_lsu_wb_cmplt_arb_pkg.sv | 29 ++
 rtl/ct_lsu_wb_cmplt_arb_rr_arb.sv | 78 +++++++
 rtl/ct_lsu_wb_cmplt_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ct_lsu_wb_cmplt_arb_pkg.sv
// -----------------------------------------------------------------------------
// ct_lsu_wb_cmplt_arb_pkg
// Shared constants and types for the LSU completion write-back arbiter.
//   PA_WIDTH       physical address / mtval width
//   LSU_IID_WIDTH  LSU instruction id width
//   STARVE_CNT_W   width of the fixed-priority starvation counters (limit 1..15)
//   arb_mode_e     arbitration policy selector
//   wb_flags_t     single-bit completion attributes of the winning source
// -----------------------------------------------------------------------------
package ct_lsu_wb_cmplt_arb_pkg;

    localparam int PA_WIDTH      = 40;
    localparam int LSU_IID_WIDTH = 7;
    localparam int STARVE_CNT_W  = 4;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic expt_vld;
        logic spec_fail;
        logic inst_flush;
        logic bkpta;
        logic bkptb;
    } wb_flags_t;

endpackage

// File: rtl/ct_lsu_wb_cmplt_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// ct_lsu_wb_rr_arb
// Round-robin arbiter for NUM_REQ requesters. The search for a winner starts at
// the pointer; requesters at or above the pointer are preferred (masked search),
// falling back to the lowest requester overall (unmasked search) on wrap.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (pointer -> 0)
//   i_flush  suppresses every grant and freezes the pointer
//   i_req    request vector
//   o_grnt   combinational one-hot grant
// -----------------------------------------------------------------------------
module ct_lsu_wb_rr_arb
    import ct_lsu_wb_cmplt_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grnt
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_grnt;
    logic [PTR_W-1:0]   w_win_idx;

    // Isolates the lowest set bit (two's complement trick).
    function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
        return v & (~v + {{(NUM_REQ-1){1'b0}}, 1'b1});
    endfunction

    // Masked/unmasked priority search starting at the pointer.
    always_comb begin
        w_masked  = '0;
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_masked[i] = i_req[i] & (PTR_W'(i) >= r_ptr);
        end
        if (|w_masked) begin
            w_pick = w_masked;
        end else begin
            w_pick = i_req;
        end
        if (i_flush) begin
            w_grnt = '0;
        end else begin
            w_grnt = lowest_onehot(w_pick);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_idx = w_win_idx | (w_grnt[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
    end

    assign o_grnt = w_grnt;

    // Pointer moves past the winner; idle and flushed cycles leave it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (|w_grnt) begin
            if (w_win_idx == LAST_IDX) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win_idx + PTR_W'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/ct_lsu_wb_cmplt_arb.sv
// -----------------------------------------------------------------------------
// ct_lsu_wb_cmplt_arb
// Completion write-back arbiter for one LSU->RTU WB pipe. Merges NUM_REQ
// completion sources onto one registered pipe (latency 1).
//   ARB_MODE 0: fixed priority (index 0 highest) with starvation promotion
//   ARB_MODE 1: round-robin (ct_lsu_wb_rr_arb)
// Ports:
//   forever_cpuclk / cpurst_b       clock, asynchronous active-low reset
//   rtu_yy_xx_flush                 global flush: kills grant and next completion
//   req_*                           per-source completion request and payload
//   req_grnt                        combinational one-hot grant
//   lsu_rtu_wb_*                    registered completion to the ROB
// -----------------------------------------------------------------------------
module ct_lsu_wb_cmplt_arb
    import ct_lsu_wb_cmplt_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int IID_W        = LSU_IID_WIDTH,
    parameter int PA_W         = PA_WIDTH
)(
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    rtu_yy_xx_flush,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*IID_W-1:0] req_iid,
    input  logic [NUM_REQ-1:0]      req_expt_vld,
    input  logic [NUM_REQ*5-1:0]    req_expt_vec,
    input  logic [NUM_REQ*PA_W-1:0] req_mtval,
    input  logic [NUM_REQ-1:0]      req_spec_fail,
    input  logic [NUM_REQ-1:0]      req_inst_flush,
    input  logic [NUM_REQ-1:0]      req_bkpta,
    input  logic [NUM_REQ-1:0]      req_bkptb,
    output logic [NUM_REQ-1:0]      req_grnt,
    output logic                    lsu_rtu_wb_cmplt,
    output logic [IID_W-1:0]        lsu_rtu_wb_iid,
    output logic                    lsu_rtu_wb_expt_vld,
    output logic [4:0]              lsu_rtu_wb_expt_vec,
    output logic [PA_W-1:0]         lsu_rtu_wb_mtval,
    output logic                    lsu_rtu_wb_spec_fail,
    output logic                    lsu_rtu_wb_flush,
    output logic                    lsu_rtu_wb_abnormal,
    output logic                    lsu_rtu_wb_bkpta_data,
    output logic                    lsu_rtu_wb_bkptb_data
);

    logic [NUM_REQ-1:0] w_arb_grnt;
    logic [NUM_REQ-1:0] w_grnt;
    logic               w_any_grnt;
    logic [IID_W-1:0]   w_win_iid;
    logic [4:0]         w_win_vec;
    logic [PA_W-1:0]    w_win_mtval;
    wb_flags_t          w_win_flags;

    logic               r_cmplt;
    logic [IID_W-1:0]   r_iid;
    logic               r_expt_vld;
    logic [4:0]         r_expt_vec;
    logic [PA_W-1:0]    r_mtval;
    logic               r_spec_fail;
    logic               r_flush;
    logic               r_abnormal;
    logic               r_bkpta;
    logic               r_bkptb;

    // Isolates the lowest set bit (two's complement trick).
    function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
        return v & (~v + {{(NUM_REQ-1){1'b0}}, 1'b1});
    endfunction

    generate
        if (ARB_MODE == int'(ARB_RR)) begin : g_rr
            ct_lsu_wb_rr_arb #(
                .NUM_REQ (NUM_REQ)
            ) u_rr_arb (
                .i_clk   (forever_cpuclk),
                .i_rst_n (cpurst_b),
                .i_flush (rtu_yy_xx_flush),
                .i_req   (req_vld),
                .o_grnt  (w_arb_grnt)
            );
        end else begin : g_fixed
            localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

            logic [STARVE_CNT_W-1:0] r_starve_cnt [NUM_REQ];
            logic [NUM_REQ-1:0]      w_promoted;
            logic [NUM_REQ-1:0]      w_pick;

            // Promoted requesters form a higher priority class; lowest index wins inside a class.
            always_comb begin
                w_promoted = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_promoted[i] = req_vld[i] & (r_starve_cnt[i] == LIMIT_C);
                end
                if (|w_promoted) begin
                    w_pick = w_promoted;
                end else begin
                    w_pick = req_vld;
                end
                if (rtu_yy_xx_flush) begin
                    w_arb_grnt = '0;
                end else begin
                    w_arb_grnt = lowest_onehot(w_pick);
                end
            end

            // Counts consecutive lost cycles per source, saturating at the promotion level.
            always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        r_starve_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (rtu_yy_xx_flush || !req_vld[i] || w_arb_grnt[i]) begin
                            r_starve_cnt[i] <= '0;
                        end else if (r_starve_cnt[i] != LIMIT_C) begin
                            r_starve_cnt[i] <= r_starve_cnt[i] + STARVE_CNT_W'(1);
                        end else begin
                            r_starve_cnt[i] <= r_starve_cnt[i];
                        end
                    end
                end
            end
        end
    endgenerate

    // No grant is issued while reset is held, so nothing can leak out mid-reset.
    always_comb begin
        if (cpurst_b) begin
            w_grnt = w_arb_grnt;
        end else begin
            w_grnt = '0;
        end
    end

    assign req_grnt   = w_grnt;
    assign w_any_grnt = |w_grnt;

    // One-hot AND-OR mux of the winner's payload.
    always_comb begin
        w_win_iid   = '0;
        w_win_vec   = '0;
        w_win_mtval = '0;
        w_win_flags = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_iid   = w_win_iid   | ({IID_W{w_grnt[i]}} & req_iid[i*IID_W +: IID_W]);
            w_win_vec   = w_win_vec   | ({5{w_grnt[i]}}     & req_expt_vec[i*5 +: 5]);
            w_win_mtval = w_win_mtval | ({PA_W{w_grnt[i]}}  & req_mtval[i*PA_W +: PA_W]);
            w_win_flags.expt_vld   = w_win_flags.expt_vld   | (w_grnt[i] & req_expt_vld[i]);
            w_win_flags.spec_fail  = w_win_flags.spec_fail  | (w_grnt[i] & req_spec_fail[i]);
            w_win_flags.inst_flush = w_win_flags.inst_flush | (w_grnt[i] & req_inst_flush[i]);
            w_win_flags.bkpta      = w_win_flags.bkpta      | (w_grnt[i] & req_bkpta[i]);
            w_win_flags.bkptb      = w_win_flags.bkptb      | (w_grnt[i] & req_bkptb[i]);
        end
    end

    // Completion valid follows the grant one cycle later; a flush already zeroed the grant.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cmplt <= 1'b0;
        end else begin
            r_cmplt <= w_any_grnt;
        end
    end

    // Completion attributes load only on a grant (clock-enable equivalent of the gated cell).
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_iid       <= '0;
            r_expt_vld  <= 1'b0;
            r_spec_fail <= 1'b0;
            r_flush     <= 1'b0;
            r_abnormal  <= 1'b0;
            r_bkpta     <= 1'b0;
            r_bkptb     <= 1'b0;
        end else if (w_any_grnt) begin
            r_iid       <= w_win_iid;
            r_expt_vld  <= w_win_flags.expt_vld;
            r_spec_fail <= w_win_flags.spec_fail;
            r_flush     <= w_win_flags.inst_flush | w_win_flags.spec_fail;
            r_abnormal  <= w_win_flags.expt_vld | w_win_flags.inst_flush | w_win_flags.spec_fail;
            r_bkpta     <= w_win_flags.bkpta;
            r_bkptb     <= w_win_flags.bkptb;
        end else begin
            r_iid       <= r_iid;
            r_expt_vld  <= r_expt_vld;
            r_spec_fail <= r_spec_fail;
            r_flush     <= r_flush;
            r_abnormal  <= r_abnormal;
            r_bkpta     <= r_bkpta;
            r_bkptb     <= r_bkptb;
        end
    end

    // Exception vector and mtval keep the last excepting completion's values.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_expt_vec <= '0;
            r_mtval    <= '0;
        end else if (w_any_grnt && w_win_flags.expt_vld) begin
            r_expt_vec <= w_win_vec;
            r_mtval    <= w_win_mtval;
        end else begin
            r_expt_vec <= r_expt_vec;
            r_mtval    <= r_mtval;
        end
    end

    assign lsu_rtu_wb_cmplt      = r_cmplt;
    assign lsu_rtu_wb_iid        = r_iid;
    assign lsu_rtu_wb_expt_vld   = r_expt_vld;
    assign lsu_rtu_wb_expt_vec   = r_expt_vec;
    assign lsu_rtu_wb_mtval      = r_mtval;
    assign lsu_rtu_wb_spec_fail  = r_spec_fail;
    assign lsu_rtu_wb_flush      = r_flush;
    assign lsu_rtu_wb_abnormal   = r_abnormal;
    assign lsu_rtu_wb_bkpta_data = r_bkpta;
    assign lsu_rtu_wb_bkptb_data = r_bkptb;

endmodule
